// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32IM execute-stage ALU.
// Base ops finish in one cycle. M-extension ops share one iterative datapath:
// shift-add for multiply and restoring division for divide. Every M op takes a
// fixed 34 cycles from accept to valid_out. ready_in is low while the datapath
// is in CALC or FIX.
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [CTRL_W-1:0] ALU_Ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              valid_out,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              busy
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [CTRL_W-1:0] OP_ADD    = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB    = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_AND    = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_OR     = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OP_XOR    = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OP_SRL    = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OP_SRA    = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SLL    = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OP_SLT    = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OP_SLTU   = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OP_PASS   = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] OP_MUL    = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] OP_MULH   = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] OP_MULHSU = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] OP_MULHU  = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] OP_DIV    = CTRL_W'(15);
  localparam logic [CTRL_W-1:0] OP_DIVU   = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] OP_REM    = CTRL_W'(17);
  localparam logic [CTRL_W-1:0] OP_REMU   = CTRL_W'(18);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic              valid_q, zero_q, busy_q;
  logic [XLEN-1:0]   result_q;
  logic [SHW-1:0]    cnt_q;
  // hi_q: upper product half / partial remainder; lo_q: multiplier / quotient
  logic [XLEN-1:0]   hi_q, lo_q, mcand_q;
  logic [CTRL_W-1:0] mop_q;
  logic              mul_q, neg_q, div0_q;

  logic              accept, is_m, is_mul;
  logic [XLEN-1:0]   base_res;
  logic              sa, sb, sgn_a, sgn_b, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_res;

  assign ready_in  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = valid_in && ready_in && !flush;
  assign is_m      = (ALU_Ctrl >= OP_MUL) && (ALU_Ctrl <= OP_REMU);
  assign is_mul    = (ALU_Ctrl >= OP_MUL) && (ALU_Ctrl <= OP_MULHU);
  assign valid_out = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

  // Single-cycle base ALU; undefined codes produce 0
  always_comb begin
    base_res = '0;
    case (ALU_Ctrl)
      OP_ADD:  base_res = op_a + op_b;
      OP_SUB:  base_res = op_a - op_b;
      OP_AND:  base_res = op_a & op_b;
      OP_OR:   base_res = op_a | op_b;
      OP_XOR:  base_res = op_a ^ op_b;
      OP_SRL:  base_res = op_a >> op_b[SHW-1:0];
      OP_SRA:  base_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      OP_SLL:  base_res = op_a << op_b[SHW-1:0];
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_PASS: base_res = op_b;
      default: base_res = '0;
    endcase
  end

  assign sa = op_a[XLEN-1];
  assign sb = op_b[XLEN-1];

  // Per-op operand signedness and final result sign for the M datapath
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    neg_d = 1'b0;
    case (ALU_Ctrl)
      OP_MULH:   begin sgn_a = sa; sgn_b = sb; neg_d = sa ^ sb; end
      OP_MULHSU: begin sgn_a = sa; neg_d = sa; end
      OP_DIV:    begin sgn_a = sa; sgn_b = sb; neg_d = sa ^ sb; end
      OP_REM:    begin sgn_a = sa; sgn_b = sb; neg_d = sa; end
      default:   ;
    endcase
  end

  assign a_mag = sgn_a ? -op_a : op_a;
  assign b_mag = sgn_b ? -op_b : op_b;

  // One iteration: shift-add multiply step or restoring divide step
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, mcand_q};
    if (mul_q) begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      // partial remainder is always below the divisor, so the low XLEN bits suffice
      hi_d = rem_ge ? (rem_sh[XLEN-1:0] - mcand_q) : rem_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], rem_ge};
    end
  end

  assign prod   = {hi_q, lo_q};
  assign prod_n = neg_q ? -prod : prod;
  assign quo_n  = neg_q ? -lo_q : lo_q;
  assign rem_n  = neg_q ? -hi_q : hi_q;

  // Sign fix-up and output select for the finished M op
  always_comb begin
    fix_res = '0;
    case (mop_q)
      OP_MUL:                        fix_res = prod_n[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_n[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = div0_q ? '1 : quo_n;
      OP_REM, OP_REMU:               fix_res = rem_n;
      default:                       fix_res = '0;
    endcase
  end

  // Control FSM with registered outputs and the iterative datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mop_q    <= '0;
      mul_q    <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            if (is_m) begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= SHW'(XLEN-1);
              hi_q    <= '0;
              lo_q    <= is_mul ? b_mag : a_mag;
              mcand_q <= is_mul ? a_mag : b_mag;
              mop_q   <= ALU_Ctrl;
              mul_q   <= is_mul;
              neg_q   <= neg_d;
              div0_q  <= (op_b == '0);
            end else begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= base_res;
              zero_q   <= (base_res == '0);
            end
          end
        end
        S_CALC: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == '0) state_q <= S_FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FIX: begin
          state_q  <= S_DONE;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          result_q <= fix_res;
          zero_q   <= (fix_res == '0);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: base ops, M-op latency and results,
// flush, stall, accept-in-DONE and asynchronous reset mid-op.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst, flush, valid_in;
  logic        ready_in, valid_out, zero, busy;
  logic [4:0]  ALU_Ctrl;
  logic [31:0] op_a, op_b, result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
  localparam logic [4:0] SRL = 5'd5,  SRA = 5'd6,  SLL = 5'd7,  SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] PASS = 5'd10, MUL = 5'd11, MULH = 5'd12, MULHSU = 5'd13, MULHU = 5'd14;
  localparam logic [4:0] DIV = 5'd15, DIVU = 5'd16, REM = 5'd17, REMU = 5'd18;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .CTRL_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_in(ready_in),
    .ALU_Ctrl(ALU_Ctrl), .op_a(op_a), .op_b(op_b), .valid_out(valid_out),
    .result(result), .zero(zero), .busy(busy)
  );

  // Present one op for one cycle, then scramble the inputs to prove capture at accept.
  task automatic drive_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    ALU_Ctrl = c; op_a = a; op_b = b; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; ALU_Ctrl = MULHSU; op_a = 32'hA5A5_5A5A; op_b = 32'h3C3C_C3C3;
  endtask

  task automatic test_reset;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", zero); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_in); end
  endtask

  task automatic test_base_b2b;
    ALU_Ctrl = ADD; op_a = 32'h7FFF_FFFF; op_b = 32'h1; valid_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", valid_out); end
    n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h want 80000000", result); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL add_zero: got %b want 0", zero); end
    ALU_Ctrl = SUB; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    valid_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL sub_valid: got %b want 1", valid_out); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL sub_result: got %h want 00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %b want 1", zero); end
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_end: got %b want 0", valid_out); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL b2b_result_hold: got %h want 00000000", result); end
  endtask

  task automatic test_base_vectors;
    logic [4:0]  vc[12];
    logic [31:0] va[12], vb[12], ve[12];
    vc = '{SRA, SLTU, SLT, AND_, OR_, XOR_, SRL, SLL, PASS, SUB, 5'd21, ADD};
    va = '{32'h8000_0000, 32'h1, 32'h1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000,
           32'h8000_0000, 32'h1, 32'h1234_5678, 32'h0, 32'h5, 32'h3};
    vb = '{32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h0F0F_0000, 32'h0F0F_0F0F,
           32'h1F, 32'h21, 32'hDEAD_BEEF, 32'h1, 32'h6, 32'h4};
    ve = '{32'hF800_0000, 32'h1, 32'h0, 32'hF000_F000, 32'hFFFF_F0F0, 32'hF0F0_0F0F,
           32'h1, 32'h2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 32'h7};
    for (int i = 0; i < 12; i++) begin
      drive_op(vc[i], va[i], vb[i]);
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL base_valid[%0d]: got %b want 1", i, valid_out); end
      n_cmp++; if (result !== ve[i]) begin n_err++; $display("FAIL base_result[%0d] op %0d: got %h want %h", i, vc[i], result, ve[i]); end
      n_cmp++; if (zero !== (ve[i] == 32'h0)) begin n_err++; $display("FAIL base_zero[%0d]: got %b want %b", i, zero, ve[i] == 32'h0); end
    end
    @(negedge clk);
  endtask

  // M op accepted in the DONE cycle of a base op.
  task automatic test_back_to_back;
    logic early;
    ALU_Ctrl = ADD; op_a = 32'd2; op_b = 32'd3; valid_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (result !== 32'd5 || valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_add: got %h/%b want 00000005/1", result, valid_out); end
    drive_op(MULHU, 32'h8000_0000, 32'h2);
    early = 1'b0;
    for (int c = 1; c < 34; c++) begin
      if (valid_out !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL b2b_m_early_valid: got %b want 0", early); end
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_m_valid: got %b want 1", valid_out); end
    n_cmp++; if (result !== 32'h1) begin n_err++; $display("FAIL b2b_m_result: got %h want 00000001", result); end
    @(negedge clk);
  endtask

  task automatic test_muldiv;
    logic [4:0]  mc[18];
    logic [31:0] ma[18], mb[18], me[18];
    logic        early, bad_busy;
    mc = '{MULH, MULHU, MULHSU, MUL, MUL, MULH, DIV, REM, DIVU, REMU, DIV, REM,
           DIV, REM, DIVU, REM, DIV, REMU};
    ma = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000,
           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
           32'd7, 32'd7, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd100};
    mb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'h8000_0000,
           32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'd0, 32'd7};
    me = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1, 32'h2345_6780, 32'h4000_0000,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
           32'hFFFF_FFFD, 32'h1, 32'hE, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h2};
    for (int i = 0; i < 18; i++) begin
      drive_op(mc[i], ma[i], mb[i]);
      early = 1'b0; bad_busy = 1'b0;
      for (int c = 1; c < 34; c++) begin
        if (valid_out !== 1'b0) early = 1'b1;
        if (busy !== 1'b1 || ready_in !== 1'b0) bad_busy = 1'b1;
        @(negedge clk);
      end
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL m_early_valid[%0d]: got %b want 0", i, early); end
      n_cmp++; if (bad_busy !== 1'b0) begin n_err++; $display("FAIL m_busy_ready[%0d]: got %b want 0", i, bad_busy); end
      n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL m_valid_t34[%0d]: got %b want 1", i, valid_out); end
      n_cmp++; if (result !== me[i]) begin n_err++; $display("FAIL m_result[%0d] op %0d: got %h want %h", i, mc[i], result, me[i]); end
      n_cmp++; if (zero !== (me[i] == 32'h0)) begin n_err++; $display("FAIL m_zero[%0d]: got %b want %b", i, zero, me[i] == 32'h0); end
    end
    last_res = me[17];
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL m_pulse_end: got %b want 0", valid_out); end
  endtask

  task automatic test_flush;
    logic stray;
    drive_op(DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", ready_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_cmp++; if (result !== last_res) begin n_err++; $display("FAIL flush_result_hold: got %h want %h", result, last_res); end
    ALU_Ctrl = ADD; op_a = 32'd10; op_b = 32'd20; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b1 || result !== 32'd30) begin n_err++; $display("FAIL flush_then_add: got %b/%h want 1/0000001e", valid_out, result); end
    stray = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out !== 1'b0) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL flush_stray_valid: got %b want 0", stray); end
    ALU_Ctrl = PASS; op_a = 32'h0; op_b = 32'h1111; valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    n_cmp++; if (valid_out !== 1'b0 || result !== 32'd30) begin n_err++; $display("FAIL flush_blocks_accept: got %b/%h want 0/0000001e", valid_out, result); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    logic bad_ready, early;
    drive_op(DIVU, 32'd100, 32'd7);
    ALU_Ctrl = ADD; op_a = 32'd1; op_b = 32'd1; valid_in = 1'b1;
    bad_ready = 1'b0; early = 1'b0;
    for (int c = 1; c < 34; c++) begin
      if (ready_in !== 1'b0) bad_ready = 1'b1;
      if (valid_out !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (bad_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_low: got %b want 0", bad_ready); end
    n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL stall_no_accept: got %b want 0", early); end
    n_cmp++; if (valid_out !== 1'b1 || result !== 32'hE) begin n_err++; $display("FAIL stall_divu: got %b/%h want 1/0000000e", valid_out, result); end
    n_cmp++; if (ready_in !== 1'b1) begin n_err++; $display("FAIL stall_done_ready: got %b want 1", ready_in); end
    @(negedge clk);
    valid_in = 1'b0;
    n_cmp++; if (valid_out !== 1'b1 || result !== 32'd2) begin n_err++; $display("FAIL done_accept_add: got %b/%h want 1/00000002", valid_out, result); end
    @(negedge clk);
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL done_accept_pulse: got %b want 0", valid_out); end
  endtask

  task automatic test_reset_midop;
    logic stray;
    drive_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h want 00000000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL midrst_zero: got %b want 1", zero); end
    n_cmp++; if (ready_in !== 1'b1 || valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_hs: got %b/%b want 1/0", ready_in, valid_out); end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out !== 1'b0) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL midrst_lost_op: got %b want 0", stray); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0;
    ALU_Ctrl = 5'd0; op_a = 32'h0; op_b = 32'h0; last_res = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_base_b2b;
    test_base_vectors;
    test_back_to_back;
    test_muldiv;
    test_flush;
    test_stall;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
